// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core encodings: writeback states, register indices, byte-lane helper
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WLO  = 3'd1,
        S_WHI  = 3'd2,
        S_WREG = 3'd3,
        S_FIN  = 3'd4
    } wb_state_e;

    localparam logic [2:0] REG_AX = 3'd0;
    localparam logic [2:0] REG_CX = 3'd1;
    localparam logic [2:0] REG_DX = 3'd2;
    localparam logic [2:0] REG_BX = 3'd3;
    localparam logic [2:0] REG_SP = 3'd4;
    localparam logic [2:0] REG_BP = 3'd5;
    localparam logic [2:0] REG_SI = 3'd6;
    localparam logic [2:0] REG_DI = 3'd7;

    localparam logic [2:0] BREG_AL = 3'd0;
    localparam logic [2:0] BREG_CL = 3'd1;
    localparam logic [2:0] BREG_DL = 3'd2;
    localparam logic [2:0] BREG_BL = 3'd3;
    localparam logic [2:0] BREG_AH = 3'd4;
    localparam logic [2:0] BREG_CH = 3'd5;
    localparam logic [2:0] BREG_DH = 3'd6;
    localparam logic [2:0] BREG_BH = 3'd7;

    // Byte codes 4-7 select the high half of AX..BX.
    function automatic logic [1:0] byte_lane_mask(input logic [2:0] byte_code);
        return byte_code[2] ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/phys_addr.sv
// rtl/phys_addr.sv - real-mode physical address: {seg,4'h0} + offset, wrapping at 20 bits
module phys_addr (
    input  logic [15:0] seg,
    input  logic [15:0] offset,
    output logic [19:0] addr
);

    assign addr = {seg, 4'h0} + {4'h0, offset};

endmodule

// File: rtl/modrm_writeback.sv
// rtl/modrm_writeback.sv - ModRM result writeback to memory (little-endian bytes) or register file
module modrm_writeback
    import core_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mem,
    input  logic        bit16,
    input  logic [15:0] seg,
    input  logic [15:0] eff,
    input  logic [2:0]  regn,
    input  logic [15:0] result,
    output logic [19:0] address,
    output logic [7:0]  out,
    output logic        wren,
    output logic        reg_we,
    output logic [2:0]  reg_idx,
    output logic [15:0] reg_wdata,
    output logic [1:0]  reg_bmask,
    output logic        busy,
    output logic        done
);

    wb_state_e   state_q, state_d;
    logic        mem_q, mem_d, bit16_q, bit16_d;
    logic [15:0] seg_q, seg_d, eff_q, eff_d, result_q, result_d;
    logic [2:0]  regn_q, regn_d;

    logic [19:0] address_q, address_d;
    logic [7:0]  out_q, out_d;
    logic        wren_q, wren_d, reg_we_q, reg_we_d, busy_q, busy_d, done_q, done_d;
    logic [2:0]  reg_idx_q, reg_idx_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic [1:0]  reg_bmask_q, reg_bmask_d;

    logic [15:0] offset;
    logic [19:0] phys;

    phys_addr u_phys_addr (
        .seg    (seg_d),
        .offset (offset),
        .addr   (phys)
    );

    // Outputs are computed for the state being entered so they are registered with it.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        bit16_d  = bit16_q;
        seg_d    = seg_q;
        eff_d    = eff_q;
        regn_d   = regn_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_d    = mem;
                    bit16_d  = bit16;
                    seg_d    = seg;
                    eff_d    = eff;
                    regn_d   = regn;
                    result_d = result;
                    state_d  = mem_d ? S_WLO : S_WREG;
                end
            end
            S_WLO:   state_d = bit16_q ? S_WHI : S_FIN;
            S_WHI:   state_d = S_FIN;
            S_WREG:  state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase

        offset      = eff_d;
        address_d   = 20'h0;
        out_d       = 8'h0;
        wren_d      = 1'b0;
        reg_we_d    = 1'b0;
        reg_idx_d   = 3'd0;
        reg_wdata_d = 16'h0;
        reg_bmask_d = 2'b00;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);

        case (state_d)
            S_WLO: begin
                wren_d    = 1'b1;
                address_d = phys;
                out_d     = result_d[7:0];
            end
            S_WHI: begin
                offset    = eff_d + 16'd1;
                wren_d    = 1'b1;
                address_d = phys;
                out_d     = result_d[15:8];
            end
            S_WREG: begin
                reg_we_d = 1'b1;
                if (bit16_d) begin
                    reg_idx_d   = regn_d;
                    reg_bmask_d = 2'b11;
                    reg_wdata_d = result_d;
                end else begin
                    reg_idx_d   = {1'b0, regn_d[1:0]};
                    reg_bmask_d = byte_lane_mask(regn_d);
                    reg_wdata_d = {result_d[7:0], result_d[7:0]};
                end
            end
            S_FIN:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_q       <= 1'b0;
            bit16_q     <= 1'b0;
            seg_q       <= 16'h0;
            eff_q       <= 16'h0;
            regn_q      <= 3'd0;
            result_q    <= 16'h0;
            address_q   <= 20'h0;
            out_q       <= 8'h0;
            wren_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= 3'd0;
            reg_wdata_q <= 16'h0;
            reg_bmask_q <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            bit16_q     <= bit16_d;
            seg_q       <= seg_d;
            eff_q       <= eff_d;
            regn_q      <= regn_d;
            result_q    <= result_d;
            address_q   <= address_d;
            out_q       <= out_d;
            wren_q      <= wren_d;
            reg_we_q    <= reg_we_d;
            reg_idx_q   <= reg_idx_d;
            reg_wdata_q <= reg_wdata_d;
            reg_bmask_q <= reg_bmask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign address   = address_q;
    assign out       = out_q;
    assign wren      = wren_q;
    assign reg_we    = reg_we_q;
    assign reg_idx   = reg_idx_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_bmask = reg_bmask_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_modrm_writeback.sv
// tb/tb_modrm_writeback.sv - table-driven bench for modrm_writeback plus reset/hold sequences
module tb_modrm_writeback;

    logic        clock = 1'b0;
    logic        reset, start, mem, bit16;
    logic [15:0] seg, eff, result;
    logic [2:0]  regn;
    logic [19:0] address;
    logic [7:0]  out;
    logic        wren, reg_we, busy, done;
    logic [2:0]  reg_idx;
    logic [15:0] reg_wdata;
    logic [1:0]  reg_bmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    modrm_writeback dut (
        .clock(clock), .reset(reset), .start(start), .mem(mem), .bit16(bit16),
        .seg(seg), .eff(eff), .regn(regn), .result(result),
        .address(address), .out(out), .wren(wren), .reg_we(reg_we),
        .reg_idx(reg_idx), .reg_wdata(reg_wdata), .reg_bmask(reg_bmask),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic        mem;
        logic        bit16;
        logic [15:0] seg;
        logic [15:0] eff;
        logic [2:0]  regn;
        logic [15:0] result;
        int          n_wr;
        logic [19:0] a0;
        logic [7:0]  d0;
        logic [19:0] a1;
        logic [7:0]  d1;
        int          n_rw;
        logic [2:0]  ridx;
        logic [1:0]  rmask;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        int nw = 0, nr = 0, done_at = 0, ndone = 0, ovl = 0, busy_lo = 0;
        logic [19:0] a0 = 0, a1 = 0;
        logic [7:0]  d0 = 0, d1 = 0;
        logic [2:0]  ri = 0;
        logic [1:0]  rm = 0;
        logic [15:0] rd = 0;
        mem = v.mem; bit16 = v.bit16; seg = v.seg; eff = v.eff;
        regn = v.regn; result = v.result; start = 1'b1;
        for (int c = 1; c <= 8 && done_at == 0; c++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            if (hold && c == 1) begin
                result = 16'h0000; eff = 16'h7777; seg = 16'h0000;
                mem = ~v.mem; bit16 = ~v.bit16; regn = ~v.regn;
            end
            if (wren && reg_we) ovl++;
            if (!busy) busy_lo++;
            if (wren) begin
                if (nw == 0) begin a0 = address; d0 = out; end
                else begin a1 = address; d1 = out; end
                nw++;
            end
            if (reg_we) begin nr++; ri = reg_idx; rm = reg_bmask; rd = reg_wdata; end
            if (done) begin done_at = c; ndone++; end
        end
        start = 1'b0;
        check("wren_count", nw, v.n_wr);
        check("addr0", a0, v.a0);
        check("data0", d0, v.d0);
        check("addr1", a1, v.a1);
        check("data1", d1, v.d1);
        check("reg_we_count", nr, v.n_rw);
        check("reg_idx", ri, v.ridx);
        check("reg_bmask", rm, v.rmask);
        check("reg_wdata", rd, v.rdata);
        check("latency", done_at, v.lat);
        check("done_count", ndone, 1);
        check("wren_reg_we_overlap", ovl, 0);
        check("busy_during_op", busy_lo, 0);
        @(negedge clock);
        check("idle_busy", busy, 1'b0);
        check("idle_outputs", {address, out, wren, reg_we, done}, 0);
    endtask

    initial begin
        vecs[0] = '{1, 1, 16'h1000, 16'h0010, 3'd0, 16'hBEEF, 2, 20'h10010, 8'hEF, 20'h10011, 8'hBE, 0, 3'd0, 2'b00, 16'h0000, 3};
        vecs[1] = '{1, 1, 16'h2000, 16'hFFFF, 3'd0, 16'h1234, 2, 20'h2FFFF, 8'h34, 20'h20000, 8'h12, 0, 3'd0, 2'b00, 16'h0000, 3};
        vecs[2] = '{1, 0, 16'hFFFF, 16'h0020, 3'd0, 16'h005A, 1, 20'h00010, 8'h5A, 20'h0, 8'h00, 0, 3'd0, 2'b00, 16'h0000, 2};
        vecs[3] = '{0, 0, 16'h0000, 16'h0000, 3'd7, 16'h00C3, 0, 20'h0, 8'h00, 20'h0, 8'h00, 1, 3'd3, 2'b10, 16'hC3C3, 2};
        vecs[4] = '{0, 1, 16'h1111, 16'h2222, 3'd5, 16'hA55A, 0, 20'h0, 8'h00, 20'h0, 8'h00, 1, 3'd5, 2'b11, 16'hA55A, 2};
        vecs[5] = '{0, 0, 16'h0000, 16'h0000, 3'd1, 16'h1234, 0, 20'h0, 8'h00, 20'h0, 8'h00, 1, 3'd1, 2'b01, 16'h3434, 2};
        vecs[6] = '{1, 1, 16'hF000, 16'hFFFF, 3'd0, 16'h9A7C, 2, 20'hFFFFF, 8'h7C, 20'hF0000, 8'h9A, 0, 3'd0, 2'b00, 16'h0000, 3};

        reset = 1'b1; start = 1'b0; mem = 1'b0; bit16 = 1'b0;
        seg = 16'h0; eff = 16'h0; regn = 3'd0; result = 16'h0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {address, out, wren, reg_we, reg_idx, reg_wdata, reg_bmask, busy, done}, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

        // start held high with inputs changing mid-write must not disturb the request
        run_vec(vecs[0], 1'b1);

        // reset in WLO of a word write aborts it
        mem = 1'b1; bit16 = 1'b1; seg = 16'h1000; eff = 16'h0010; result = 16'hBEEF; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort_wlo_wren", wren, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_outputs", {address, out, wren, reg_we, reg_idx, reg_wdata, reg_bmask, busy, done}, 0);
        begin
            int extra = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                if (wren || done || busy) extra++;
            end
            check("abort_no_activity", extra, 0);
        end

        // reset wins over a simultaneous start
        reset = 1'b1; start = 1'b1; mem = 1'b0;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("reset_over_start_busy", busy, 1'b0);
        @(negedge clock);
        check("reset_over_start_reg_we", {reg_we, wren, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modrm_writeback.md
MODRM_WRITEBACK -- requirements
Module: modrm_writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every other port is listed below.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to write one result; sampled only in IDLE.
REQ-005 mem  input  1  destination select: 1 = memory, 0 = register.
REQ-006 bit16  input  1  operand size: 1 = word, 0 = byte.
REQ-007 seg  input  16  segment value, already resolved by the caller (override, DS or SS).
REQ-008 eff  input  16  effective offset.
REQ-009 regn  input  3  ModRM register field; byte codes 0-7 = AL,CL,DL,BL,AH,CH,DH,BH.
REQ-010 result  input  16  value to store.
REQ-011 address  output  20  byte address on the memory bus.
REQ-012 out  output  8  write data on the memory bus.
REQ-013 wren  output  1  memory write enable.
REQ-014 reg_we  output  1  register-file write strobe.
REQ-015 reg_idx  output  3  index of the 16-bit destination register.
REQ-016 reg_wdata  output  16  register write data.
REQ-017 reg_bmask  output  2  byte enables: bit0 = low byte, bit1 = high byte.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, WLO, WHI, WREG and FIN.
REQ-021 IDLE + start SHALL latch mem, bit16, seg, eff, regn and result, then go to WLO if mem = 1, else to WREG.
REQ-022 IDLE without start SHALL stay in IDLE.
REQ-023 start outside IDLE SHALL be ignored; the latched fields SHALL NOT change.
REQ-024 WLO SHALL drive wren = 1, address = ({seg,4'h0} + eff) mod 2^20 and out = result[7:0].
REQ-025 WLO SHALL go to WHI if bit16 = 1, else to FIN.
REQ-026 WHI SHALL drive wren = 1, address = ({seg,4'h0} + ((eff+1) mod 2^16)) mod 2^20 and out = result[15:8], then go to FIN.
REQ-027 In WHI the offset SHALL wrap within the segment (eff = FFFFh gives offset 0000h); the physical sum SHALL wrap at 20 bits.
REQ-028 WREG SHALL pulse reg_we = 1 for exactly one cycle, then go to FIN.
REQ-029 WREG with bit16 = 1 SHALL drive reg_idx = regn, reg_bmask = 11 and reg_wdata = result.
REQ-030 WREG with bit16 = 0 SHALL drive reg_idx = {1'b0, regn[1:0]} and reg_wdata = {result[7:0], result[7:0]}.
REQ-031 In that byte case reg_bmask SHALL be 01 if regn[2] = 0 and 10 if regn[2] = 1.
REQ-032 FIN SHALL pulse done = 1 for one cycle, then return to IDLE.
REQ-033 Latency from the start cycle to the done cycle SHALL be 3 cycles for a memory word, 2 for a memory byte and 2 for a register write.
REQ-034 Outside WLO/WHI, wren SHALL be 0, address 0 and out 0.
REQ-035 Outside WREG, reg_we SHALL be 0.
REQ-036 wren and reg_we SHALL never be high in the same cycle.
REQ-037 Byte order SHALL be little-endian: low byte first, at the lower offset.

Reset
REQ-038 Reset SHALL force IDLE on the next edge, from any state.
REQ-039 On reset, wren, reg_we, busy and done SHALL go to 0, and address, out, reg_idx, reg_wdata and reg_bmask SHALL go to 0.
REQ-040 Reset during WLO or WHI SHALL abort the write: no further wren cycle and no done pulse.
REQ-041 Reset has priority over a start in the same cycle.

Structure
REQ-042 State encoding and the register-index constants (AX..DI, byte codes) SHALL live in shared package core_pkg.
REQ-043 The 20-bit physical-address adder SHALL be one sub-module, phys_addr (seg, offset -> 20-bit address), shared with the fetch path.

Verification
REQ-044 Memory word: seg=1000h, eff=0010h, result=BEEFh -> wren cycle 1 at 10010h/EFh, wren cycle 2 at 10011h/BEh, done next cycle.
REQ-045 Offset wrap: seg=2000h, eff=FFFFh, word 1234h -> 2FFFFh/34h, then 20000h/12h.
REQ-046 20-bit wrap: seg=FFFFh, eff=0020h, byte 5Ah -> single write at 00010h/5Ah; done 2 cycles after start.
REQ-047 Register byte: mem=0, bit16=0, regn=7 (BH), result=00C3h -> reg_we once, reg_idx=3, reg_bmask=10, reg_wdata=C3C3h, no wren.
REQ-048 start held high throughout a memory word write -> exactly 2 wren cycles and 1 done pulse per request.
REQ-049 Reset asserted in WLO of a word write -> wren 0 on the next cycle, WHI never entered, no done pulse, busy=0.
